linha_scroll_row: RTL

Parametrised successor to the fixed 5-column LED-matrix row register. Holds one matrix row of COLS pixels and scrolls it serially at a programmable rate. Supports left/right direction, rotate or shift-in, parallel load and pause. Drives the selected column pixel to the matrix driver, which sweeps `counter` across the columns, and flags frame boundaries for the message sequencer.

---
 rtl/linha_scroll_row.sv | 113 +++++++++++
 1 files changed

// File: rtl/linha_scroll_row.sv
// linha_scroll_row: one LED-matrix row that scrolls at a programmable rate, with load and pause.
// Optional LINHA_BLINK_EN gates led_out with a phase bit that toggles each frame.
module linha_scroll_row #(
  parameter int unsigned COLS      = 5,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned SHIFT_DIV = 1
) (
  input  logic             clk_6hz,
  input  logic             rst,
  input  logic             new_data_in,
  input  logic             load,
  input  logic [COLS-1:0]  load_data,
  input  logic             dir,
  input  logic             rotate,
  input  logic             pause,
  input  logic [SEL_W-1:0] counter,
  output logic             led_out,
  output logic [COLS-1:0]  row_q,
  output logic             shift_pulse,
  output logic             wrap_pulse
);

  localparam int unsigned DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int unsigned POS_W = $clog2(COLS);
  localparam int unsigned SEL_N = 1 << SEL_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(COLS - 1);

  logic [COLS-1:0]  row;
  logic [DIV_W-1:0] div_cnt;
  logic [POS_W-1:0] pos;
  logic             shift_now;
  logic             wrap_now;
  logic             in_bit;
  logic [COLS-1:0]  shifted_row;
  logic [SEL_N-1:0] col_vec;
  logic             blink_gate;

  // Shift decision and next row contents for the current direction/mode
  always_comb begin
    shift_now   = 1'b0;
    wrap_now    = 1'b0;
    in_bit      = new_data_in;
    shifted_row = row;
    shift_now   = !load && !pause && (div_cnt == DIV_LAST);
    wrap_now    = shift_now && (pos == POS_LAST);
    if (rotate) begin
      in_bit = dir ? row[0] : row[COLS-1];
    end
    if (dir) begin
      shifted_row = {in_bit, row[COLS-1:1]};
    end else begin
      shifted_row = {row[COLS-2:0], in_bit};
    end
  end

  always_ff @(posedge clk_6hz) begin
    if (!rst) begin
      row         <= '0;
      div_cnt     <= '0;
      pos         <= '0;
      shift_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      shift_pulse <= shift_now;
      wrap_pulse  <= wrap_now;
      if (load) begin
        row     <= load_data;
        div_cnt <= '0;
        pos     <= '0;
      end else if (!pause) begin
        if (shift_now) begin
          row     <= shifted_row;
          div_cnt <= '0;
          pos     <= wrap_now ? '0 : pos + POS_W'(1);
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef LINHA_BLINK_EN
  logic phase;

  // Frame phase: blank the display on every other frame
  always_ff @(posedge clk_6hz) begin
    if (!rst) begin
      phase <= 1'b1;
    end else if (load) begin
      phase <= 1'b1;
    end else if (wrap_now) begin
      phase <= ~phase;
    end
  end

  assign blink_gate = phase;
`else
  assign blink_gate = 1'b1;
`endif

  // Column view: scan select 0 addresses the highest row bit; unused selects read 0
  always_comb begin
    col_vec = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      col_vec[i] = row[COLS-1-i];
    end
  end

  assign led_out = col_vec[counter] & blink_gate;
  assign row_q   = row;

endmodule
